// File: rtl/clk_meter_pkg.sv
// clk_meter_pkg: shared types and defaults for the clk_in period meter.
// Holds the measurement FSM encoding and default counter sizing.
`timescale 1ns/1ps
package clk_meter_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARM     = 2'd1,
      MEASURE = 2'd2
   } meter_state_t;

   localparam int CNT_W_DEF   = 33;
   localparam int TIMEOUT_DEF = 100_000_000;

endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: brings clk_in into the clk domain and flags its
// rising edges one cycle wide.
`timescale 1ns/1ps
module sync_edge_det (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic rise
);

   logic s1;
   logic s2;
   logic s3;

   // two-flop synchronizer followed by a history flop for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/clk_period_meter.sv
// clk_period_meter: counts clk cycles between rising edges of a slow
// asynchronous clk_in and hands each period out on a valid/ready pair.
`timescale 1ns/1ps
module clk_period_meter
   import clk_meter_pkg::*;
#(
   parameter int CNT_W   = CNT_W_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clk_in,
   input  logic             en,
   output logic             edge_tick,
   output logic [CNT_W-1:0] period,
   output logic             period_valid,
   input  logic             period_ready,
   output logic             timeout,
   output logic             overrun
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   meter_state_t     state;
   logic [CNT_W-1:0] cnt;
   logic             rise;
   logic             cap;
   logic             load;

   sync_edge_det u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (clk_in),
      .rise  (rise)
   );

   assign edge_tick = rise & en;

   // a capture is a rise seen while timing; it is only loaded when
   // the output slot is free or being drained in the same cycle
   assign cap  = en & rise & (state == MEASURE);
   assign load = cap & (~period_valid | period_ready);

   // measurement FSM, period counter and result handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         period       <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         overrun      <= 1'b0;
      end else if (!en) begin
         state        <= IDLE;
         cnt          <= '0;
         period_valid <= 1'b0;
         timeout      <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         if (period_valid && period_ready && !cap)
            period_valid <= 1'b0;

         if (load) begin
            period       <= cnt;
            period_valid <= 1'b1;
            timeout      <= 1'b0;
         end else if (cap) begin
            overrun      <= 1'b1;
         end

         case (state)
            IDLE: begin
               cnt   <= '0;
               state <= ARM;
            end
            ARM: begin
               if (rise) begin
                  cnt   <= CNT_ONE;
                  state <= MEASURE;
               end else begin
                  cnt   <= '0;
               end
            end
            MEASURE: begin
               // a rise on the last count still wins over the timeout
               if (rise) begin
                  cnt <= CNT_ONE;
               end else if (cnt == CNT_LAST) begin
                  cnt     <= '0;
                  timeout <= 1'b1;
                  state   <= ARM;
               end else begin
                  cnt <= cnt + CNT_ONE;
               end
            end
            default: begin
               cnt   <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
